// File: rtl/map9v3_sched_pkg.sv
// Shared types and defaults for the map9v3 job scheduler.
package map9v3_sched_pkg;

  localparam int NW_DEF = 9;
  localparam int SW_DEF = 8;

  typedef logic id_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_ARM,
    S_RUN,
    S_RESP
  } state_t;

  function automatic logic [1:0] id_onehot(input id_t id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/map9v3_sched_rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the requester that currently
// has priority and moves past whoever was just served.
module rr_arb2
  import map9v3_sched_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  input  id_t        served,
  output logic [1:0] gnt
);

  id_t ptr;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr <= 1'b0;
    end else if (advance) begin
      ptr <= ~served;
    end
  end

  always_comb begin
    gnt = 2'b00;
    if (req[ptr]) begin
      gnt = id_onehot(ptr);
    end else if (req[~ptr]) begin
      gnt = id_onehot(~ptr);
    end
  end

endmodule

// File: rtl/map9v3_sched.sv
// Round-robin job scheduler owning the start/N inputs of one map9v3 engine.
// Optional watchdog: define MAP9V3_SCHED_WATCHDOG_EN to abort jobs after TIMEOUT cycles.
//
// Handshakes: a request transfers on a rising edge where req_valid[i] & req_ready[i];
// a response transfers on a rising edge where rsp_valid & rsp_ready. Neither valid
// may depend on its ready, and the offering side holds its payload until transfer.
module map9v3_sched
  import map9v3_sched_pkg::*;
#(
  parameter int NW      = NW_DEF,
  parameter int SW      = SW_DEF,
  parameter int TIMEOUT = 4096
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [1:0]    req_valid,
  input  logic [NW-1:0] req_n0,
  input  logic [NW-1:0] req_n1,
  output logic [1:0]    req_ready,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_id,
  output logic [NW-1:0] rsp_dp,
  output logic [SW-1:0] rsp_sr,
  output logic          rsp_err,
  output logic          busy,
  output logic          eng_start,
  output logic [NW-1:0] eng_n,
  input  logic          eng_done,
  input  logic [NW-1:0] eng_dp,
  input  logic [SW-1:0] eng_sr
);

  state_t     state, state_nx;
  logic [1:0] gnt;
  logic [1:0] ready_q;
  logic [1:0] take;
  logic       accept;
  logic       done_hit;
  logic       timeout_hit;
  id_t        cur_id;

  assign req_ready = ready_q;
  assign take      = req_valid & ready_q;
  assign accept    = (state == S_IDLE) && (take != 2'b00);
  assign done_hit  = (state == S_RUN) && eng_done;

  rr_arb2 u_arb (
    .clock   (clock),
    .reset   (reset),
    .req     (req_valid),
    .advance (accept),
    .served  (take[1]),
    .gnt     (gnt)
  );

`ifdef MAP9V3_SCHED_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wd_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wd_cnt <= '0;
    end else if (state == S_START) begin
      wd_cnt <= '0;
    end else if (state == S_ARM || state == S_RUN) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  assign timeout_hit = (state == S_ARM || state == S_RUN) && (wd_cnt == CW'(TIMEOUT - 1));
`else
  // Constant false: without the watchdog ARM/RUN wait for the engine indefinitely.
  assign timeout_hit = (TIMEOUT < 0);
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (accept) state_nx = S_START;
      S_START: state_nx = S_ARM;
      // ARM waits for the engine to leave the done level left over from the last job.
      S_ARM: begin
        if (timeout_hit)    state_nx = S_RESP;
        else if (!eng_done) state_nx = S_RUN;
      end
      S_RUN:   if (eng_done || timeout_hit) state_nx = S_RESP;
      S_RESP:  if (rsp_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    eng_start = (state == S_START);
    busy      = (state != S_IDLE);
    rsp_valid = (state == S_RESP);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ready_q <= 2'b00;
      eng_n   <= '0;
      cur_id  <= 1'b0;
      rsp_id  <= 1'b0;
      rsp_dp  <= '0;
      rsp_sr  <= '0;
      rsp_err <= 1'b0;
    end else begin
      // Grant is offered one cycle after IDLE is entered, so jobs are spaced by two idle cycles.
      ready_q <= (state == S_IDLE && !accept) ? gnt : 2'b00;
      if (accept) begin
        eng_n  <= take[1] ? req_n1 : req_n0;
        cur_id <= take[1];
      end
      if (done_hit) begin
        rsp_id  <= cur_id;
        rsp_dp  <= eng_dp;
        rsp_sr  <= eng_sr;
        rsp_err <= 1'b0;
      end else if (timeout_hit) begin
        rsp_id  <= cur_id;
        rsp_dp  <= '0;
        rsp_sr  <= '0;
        rsp_err <= 1'b1;
      end
    end
  end

endmodule
